// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one 8-bit AXI-Stream TX port.
// A stall watchdog terminates a stuck frame with a tuser-marked beat and flushes the remainder.
module eth_tx_frame_arbiter #(
  parameter int unsigned PORTS   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               logic_clk,
  input  logic               logic_rst_n,
  input  logic [PORTS-1:0]   port_enable,
  input  logic [PORTS*8-1:0] s_axis_tdata,
  input  logic [PORTS-1:0]   s_axis_tvalid,
  output logic [PORTS-1:0]   s_axis_tready,
  input  logic [PORTS-1:0]   s_axis_tlast,
  input  logic [PORTS-1:0]   s_axis_tuser,
  output logic [7:0]         m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser,
  output logic [PORTS-1:0]   grant,
  output logic               abort,
  output logic [15:0]        abort_count
);

  localparam int unsigned PtrW = $clog2(PORTS);
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(PORTS - 1);

  typedef enum logic [1:0] {StIdle, StPass, StAbort, StFlush} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]   owner_q, owner_d;
  logic [PORTS-1:0]  grant_q, grant_d;
  logic [CntW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [15:0]       abort_count_q, abort_count_d;

  logic [PORTS-1:0]  req;
  logic              found;
  logic [PtrW-1:0]   winner;
  logic              owner_valid, owner_last, owner_user, owner_xfer;
  logic [7:0]        owner_data;

  // Scan offsets high to low so the lowest offset from rr_ptr wins.
  always_comb begin
    int unsigned idx;
    req    = s_axis_tvalid & port_enable;
    found  = 1'b0;
    winner = rr_ptr_q;
    for (int k = PORTS - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % PORTS;
      if (req[idx]) begin
        found  = 1'b1;
        winner = PtrW'(idx);
      end
    end
  end

  assign owner_valid = s_axis_tvalid[owner_q];
  assign owner_last  = s_axis_tlast[owner_q];
  assign owner_user  = s_axis_tuser[owner_q];
  assign owner_data  = s_axis_tdata[{owner_q, 3'b000} +: 8];
  assign owner_xfer  = owner_valid & m_axis_tready;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    grant_d       = grant_q;
    idle_cnt_d    = idle_cnt_q;
    abort_count_d = abort_count_q;
    m_axis_tdata  = 8'h00;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = '0;
    abort         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d    = PORTS'(1) << winner;
          owner_d    = winner;
          rr_ptr_d   = (winner == PtrLast) ? '0 : winner + 1'b1;
          idle_cnt_d = '0;
          state_d    = StPass;
        end
      end
      StPass: begin
        m_axis_tdata           = owner_data;
        m_axis_tvalid          = owner_valid;
        m_axis_tlast           = owner_last;
        m_axis_tuser           = owner_user;
        s_axis_tready[owner_q] = m_axis_tready;
        if (owner_xfer) begin
          idle_cnt_d = '0;
          if (owner_last) begin
            grant_d = '0;
            state_d = StIdle;
          end
        end else if (!owner_valid && TIMEOUT != 0) begin
          // Backpressured cycles (valid but not ready) hold the count.
          if (idle_cnt_q == CntLast) begin
            state_d = StAbort;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      StAbort: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
        if (m_axis_tready) begin
          abort = 1'b1;
          if (abort_count_q != 16'hFFFF) abort_count_d = abort_count_q + 16'd1;
          state_d = StFlush;
        end
      end
      StFlush: begin
        s_axis_tready[owner_q] = 1'b1;
        if (owner_valid && owner_last) begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      grant_q       <= '0;
      idle_cnt_q    <= '0;
      abort_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      grant_q       <= grant_d;
      idle_cnt_q    <= idle_cnt_d;
      abort_count_q <= abort_count_d;
    end
  end

  assign grant       = grant_q;
  assign abort_count = abort_count_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench: dut_a (TIMEOUT=8) and dut_b (TIMEOUT=4) share all stimulus.
// Sources follow dut_a's handshake; both DUTs see identical traffic except during stalls.
module tb_eth_tx_frame_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  port_enable;
  logic [31:0] tdata;
  logic [3:0]  tvalid, tlast, tuser;
  logic        m_tready;

  logic [3:0]  s_tready_a, grant_a, s_tready_b, grant_b;
  logic [7:0]  m_tdata_a, m_tdata_b;
  logic        m_tvalid_a, m_tlast_a, m_tuser_a, abort_a;
  logic        m_tvalid_b, m_tlast_b, m_tuser_b, abort_b;
  logic [15:0] abort_count_a, abort_count_b;

  int n_checks = 0;
  int n_pass   = 0;
  int bidx[4];
  int flen[4];
  int base[4];

  eth_tx_frame_arbiter #(.PORTS(4), .TIMEOUT(8)) dut_a (
    .logic_clk(clk), .logic_rst_n(rst_n), .port_enable(port_enable),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(s_tready_a),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .m_axis_tdata(m_tdata_a), .m_axis_tvalid(m_tvalid_a), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast_a), .m_axis_tuser(m_tuser_a),
    .grant(grant_a), .abort(abort_a), .abort_count(abort_count_a)
  );

  eth_tx_frame_arbiter #(.PORTS(4), .TIMEOUT(4)) dut_b (
    .logic_clk(clk), .logic_rst_n(rst_n), .port_enable(port_enable),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(s_tready_b),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .m_axis_tdata(m_tdata_b), .m_axis_tvalid(m_tvalid_b), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast_b), .m_axis_tuser(m_tuser_b),
    .grant(grant_b), .abort(abort_b), .abort_count(abort_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic src_apply();
    for (int p = 0; p < 4; p++) begin
      tdata[p*8 +: 8] = 8'(base[p] + bidx[p]);
      tlast[p]        = (bidx[p] == flen[p] - 1);
    end
  endtask

  // Advance one clock; sources step to their next byte after an accepted beat.
  task automatic src_step();
    logic [3:0] xfer;
    xfer = tvalid & s_tready_a;
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++)
      if (xfer[p]) bidx[p] = (bidx[p] == flen[p] - 1) ? 0 : bidx[p] + 1;
    src_apply();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order[6];
    int got;
    logic abort_seen;
    order = '{0, 1, 3, 0, 1, 3};
    for (int p = 0; p < 4; p++) begin
      bidx[p] = 0;
      flen[p] = 1;
      base[p] = 0;
    end
    rst_n = 1'b0; port_enable = 4'b1111; tdata = '0; tvalid = '0; tlast = '0;
    tuser = '0; m_tready = 1'b1;
    #1;
    check("rst_grant", grant_a, 4'b0000);
    check("rst_tvalid", m_tvalid_a, 1'b0);
    check("rst_tready", s_tready_a, 4'b0000);
    check("rst_tdata", m_tdata_a, 8'h00);
    check("rst_abort_count", abort_count_a, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-source frame: port 2 sends 01..05.
    base[2] = 1; flen[2] = 5; tvalid[2] = 1'b1;
    src_apply();
    #1;
    check("t1_idle_grant", grant_a, 4'b0000);
    src_step();
    for (int i = 1; i <= 5; i++) begin
      check("t1_grant", grant_a, 4'b0100);
      check("t1_tdata", m_tdata_a, 32'(i));
      check("t1_tlast", m_tlast_a, (i == 5));
      src_step();
    end
    tvalid[2] = 1'b0;
    #1;
    check("t1_grant_clear", grant_a, 4'b0000);
    check("t1_tvalid_idle", m_tvalid_a, 1'b0);

    // Round robin among ports 0,1,3 from a fresh rr_ptr.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int p = 0; p < 4; p++) begin
      base[p] = p * 16; flen[p] = 3; bidx[p] = 0;
    end
    tvalid = 4'b1011;
    src_apply();
    #1;
    for (int f = 0; f < 6; f++) begin
      check("t2_idle_gap", grant_a, 4'b0000);
      src_step();
      for (int b = 0; b < 3; b++) begin
        check("t2_grant", grant_a, 32'(1 << order[f]));
        check("t2_tdata", m_tdata_a, 32'(order[f] * 16 + b));
        check("t2_tlast", m_tlast_a, (b == 2));
        src_step();
      end
    end
    tvalid = 4'b0000;
    #1;

    // Backpressure on a 64-byte frame, checked on the TIMEOUT=4 instance.
    base[0] = 0; flen[0] = 64; bidx[0] = 0; tvalid[0] = 1'b1;
    src_apply();
    #1;
    got = 0;
    abort_seen = 1'b0;
    for (int c = 0; c < 300 && got < 64; c++) begin
      abort_seen |= abort_b;
      if (m_tvalid_b && m_tready) begin
        check("t3_tdata", m_tdata_b, 32'(got[7:0]));
        check("t3_tlast", m_tlast_b, (got == 63));
        got++;
      end
      src_step();
      m_tready = ~m_tready;
      #1;
    end
    tvalid[0] = 1'b0;
    m_tready = 1'b1;
    #1;
    check("t3_byte_count", got, 64);
    check("t3_no_abort", abort_seen, 1'b0);
    check("t3_abort_count", abort_count_b, 16'h0000);
    check("t3_grant_clear", grant_b, 4'b0000);

    // Stall abort on port 1 with TIMEOUT=8.
    base[1] = 8'h20; flen[1] = 7; bidx[1] = 0; tvalid[1] = 1'b1;
    src_apply();
    #1;
    check("t4_idle", grant_a, 4'b0000);
    src_step();
    for (int b = 0; b < 3; b++) begin
      check("t4_tdata", m_tdata_a, 32'(8'h20 + b));
      src_step();
    end
    tvalid[1] = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      check("t4_stall_tvalid", m_tvalid_a, 1'b0);
      check("t4_stall_grant", grant_a, 4'b0010);
      check("t4_stall_abort", abort_a, 1'b0);
      src_step();
    end
    tvalid[1] = 1'b1;
    #1;
    check("t4_abort_tvalid", m_tvalid_a, 1'b1);
    check("t4_abort_tdata", m_tdata_a, 8'h00);
    check("t4_abort_tlast", m_tlast_a, 1'b1);
    check("t4_abort_tuser", m_tuser_a, 1'b1);
    check("t4_abort_pulse", abort_a, 1'b1);
    check("t4_abort_tready", s_tready_a, 4'b0000);
    src_step();
    check("t4_abort_count", abort_count_a, 16'h0001);
    check("t4_abort_pulse_end", abort_a, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t4_flush_tvalid", m_tvalid_a, 1'b0);
      check("t4_flush_tready", s_tready_a, 4'b0010);
      src_step();
    end
    tvalid[1] = 1'b0;
    #1;
    check("t4_idle_after", grant_a, 4'b0000);
    check("t4_abort_count_hold", abort_count_a, 16'h0001);

    // Port mask blocks arbitration until enabled.
    port_enable = 4'b0000;
    base[0] = 8'h5A; flen[0] = 1; bidx[0] = 0; tvalid[0] = 1'b1;
    src_apply();
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t5_masked_grant", grant_a, 4'b0000);
      check("t5_masked_tvalid", m_tvalid_a, 1'b0);
      src_step();
    end
    port_enable = 4'b1111;
    #1;
    src_step();
    check("t5_enabled_grant", grant_a, 4'b0001);
    check("t5_enabled_tdata", m_tdata_a, 8'h5A);
    src_step();
    tvalid[0] = 1'b0;
    #1;
    check("t5_enabled_done", grant_a, 4'b0000);

    // Saturation: preload the counter just below the limit, then abort twice.
    force dut_b.abort_count_q = 16'hFFFE;
    #1;
    release dut_b.abort_count_q;
    #1;
    check("t5_preload", abort_count_b, 16'hFFFE);
    for (int n = 0; n < 2; n++) begin
      tvalid[0] = 1'b1;
      src_apply();
      #1;
      tick();
      tvalid[0] = 1'b0;
      repeat (4) tick();
      #1;
      check("t5_sat_abort", abort_b, 1'b1);
      tick();
      check("t5_sat_count", abort_count_b, 16'hFFFF);
      tvalid[0] = 1'b1;
      #1;
      tick();
      tvalid[0] = 1'b0;
      #1;
      check("t5_sat_idle", grant_b, 4'b0000);
    end

    // Asynchronous reset during the third byte of a port 0 frame.
    base[0] = 8'h40; flen[0] = 5; bidx[0] = 0; tvalid[0] = 1'b1;
    src_apply();
    #1;
    src_step();
    src_step();
    src_step();
    check("t6_byte3", m_tdata_a, 8'h42);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_tvalid", m_tvalid_a, 1'b0);
    check("t6_rst_tready", s_tready_a, 4'b0000);
    check("t6_rst_grant", grant_a, 4'b0000);
    check("t6_rst_abort_count", abort_count_a, 16'h0000);
    for (int p = 0; p < 4; p++) bidx[p] = 0;
    base[1] = 8'h50; flen[1] = 1;
    tvalid = 4'b0011;
    src_apply();
    #2;
    rst_n = 1'b1;
    tick();
    #1;
    check("t6_port0_first", grant_a, 4'b0001);
    check("t6_port0_data", m_tdata_a, 8'h40);
    tvalid = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_tx_frame_arbiter.md
# eth_tx_frame_arbiter

Frame-granular round-robin arbiter sharing the single 8-bit AXI-Stream transmit input of the RGMII MAC/FIFO wrapper among several frame sources (UDP, ARP, ICMP, debug) in the `logic_clk` domain. It never interleaves bytes of different frames. A stall watchdog terminates a frame whose source stops mid-frame: it emits a `tuser`-marked last beat so the TX frame FIFO drops the frame, then discards the rest of the stalled source's frame.

## Interface
- `PORTS`, default 4: number of requesters, legal range 2..8.
- `TIMEOUT`, default 1024: consecutive granted-source idle cycles before abort; 0 disables the watchdog.
- `logic_clk` in, 1: the only clock.
- `logic_rst_n` in, 1: asynchronous assert, active-low reset.
- `port_enable` in, PORTS: per-port request mask; sampled only at arbitration.
- `s_axis_tdata` in, PORTS*8: port i occupies bits [8i+7:8i].
- `s_axis_tvalid` in, PORTS.
- `s_axis_tready` out, PORTS.
- `s_axis_tlast` in, PORTS.
- `s_axis_tuser` in, PORTS: bad-frame marker, passed through.
- `m_axis_tdata` out, 8: to the MAC FIFO `tx_axis_tdata`.
- `m_axis_tvalid` out, 1.
- `m_axis_tready` in, 1.
- `m_axis_tlast` out, 1.
- `m_axis_tuser` out, 1.
- `grant` out, PORTS: one-hot owner, all-zero in IDLE.
- `abort` out, 1: one-cycle pulse when an abort beat is accepted.
- `abort_count` out, 16: saturating count of aborts.

## Operation
- States:
  - IDLE: no owner.
  - PASS: owner's stream muxed to the output.
  - ABORT: emitting the terminating beat.
  - FLUSH: discarding the rest of the owner's frame.
- IDLE:
  - A request is `s_axis_tvalid[i] & port_enable[i]`.
  - If any request exists, choose the first requesting port searching from `rr_ptr` upward with wrap.
  - Load `grant`, set `rr_ptr` to winner+1 (mod PORTS), go to PASS.
  - If no request exists, stay in IDLE.
- PASS:
  - `m_axis_tdata/tvalid/tlast/tuser` equal the owner's inputs.
  - `s_axis_tready[owner]` = `m_axis_tready`; all other `s_axis_tready` = 0.
  - When a beat with tlast=1 transfers, go to IDLE and clear `grant`.
- Watchdog (PASS only):
  - `idle_cnt` increments on each cycle with owner `s_axis_tvalid`=0.
  - It clears on any transfer and on entry to PASS.
  - Cycles with tvalid=1 and `m_axis_tready`=0 (MAC backpressure) hold the count.
  - When the count reaches TIMEOUT, go to ABORT.
- ABORT:
  - Drive `m_axis_tvalid`=1, tdata=8'h00, tlast=1, tuser=1.
  - All `s_axis_tready`=0.
  - When `m_axis_tready`=1: pulse `abort`, increment `abort_count` (saturating at 16'hFFFF), go to FLUSH.
- FLUSH:
  - `m_axis_tvalid`=0; `s_axis_tready[owner]`=1.
  - Discard owner beats until a beat with tlast=1 is consumed, then go to IDLE.
  - No timeout applies in FLUSH.
- Disabling a port mid-frame does not affect the frame in progress.
- Widths:
  - `rr_ptr` is $clog2(PORTS) bits.
  - `idle_cnt` is $clog2(TIMEOUT+1) bits and is never compared when TIMEOUT=0.

## Timing
- Reset values: state IDLE, `rr_ptr`=0 (port 0 first), `grant`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `m_axis_tdata`=0, all `s_axis_tready`=0, `abort`=0, `abort_count`=0.
- Arbitration latency:
  - Request seen in IDLE at edge N means `grant` is valid after N.
  - The first beat can transfer in cycle N+1.
- Datapath is a combinational mux in PASS: zero added latency, no buffering, tvalid/tready obey AXI-Stream rules (no tvalid drop without transfer except in ABORT/FLUSH transitions owned by the arbiter).
- Back-to-back frames: exactly one IDLE cycle between a tlast transfer and the next first beat.
- Abort timing: the ABORT beat is presented on the cycle after TIMEOUT consecutive idle cycles.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). The partial frame is left to the FIFO; the FIFO side is reset together with the MAC.

## Test plan
1. Single-source frame:
   - Stimulus: port 2 sends 5 bytes 01..05 (tlast on 05), `m_axis_tready`=1.
   - Response: `grant`=0100 one cycle after tvalid; output 01..05 on consecutive cycles; tlast on 05; then `grant`=0.
2. Round-robin:
   - Stimulus: ports 0, 1, 3 continuously request 3-byte frames.
   - Response: grant order 0, 1, 3, 0, 1, 3; exactly one IDLE cycle between frames; no byte interleave.
3. Backpressure:
   - Stimulus: `m_axis_tready` toggles 1/0 during a 64-byte frame with TIMEOUT=4.
   - Response: all 64 bytes delivered in order; no abort; `abort_count`=0.
4. Stall abort:
   - Stimulus: TIMEOUT=8; port 1 sends 3 bytes, drops tvalid for 8 cycles, then sends 4 more bytes ending in tlast.
   - Response: ABORT beat {00, tlast=1, tuser=1}; `abort` pulses once; `abort_count`=1; the 4 late bytes are consumed with `m_axis_tvalid`=0; then IDLE.
5. Mask and saturation:
   - Stimulus: `port_enable`=0000 with port 0 valid.
   - Response: no grant.
   - Stimulus: force 65536 aborts.
   - Response: `abort_count` holds FFFF.
6. Reset mid-frame:
   - Stimulus: deassert `logic_rst_n` during byte 3 of a frame.
   - Response: `m_axis_tvalid`, `s_axis_tready`, `grant` go to 0 without waiting for a clock edge; after release, port 0 wins first.
